muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; the ports SHALL be named clk and reset.
REQ-002 Port list (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_1  input  32  operand rs1, sampled with start
- in_2  input  32  operand rs2, sampled with start
- kill  input  1  abort the in-flight operation (pipeline flush)
- busy  output  1  operation in progress; EX stage stalls while high
- done  output  1  one-cycle pulse: result valid
- result  output  32  operation result; held until the next accepted start

Function
REQ-003 The block SHALL implement a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-004 IDLE or DONE with start=1 SHALL latch op, in_1 and in_2 and enter CALC at the next edge; otherwise DONE SHALL return to IDLE.
REQ-005 CALC SHALL run exactly 32 iterations (6-bit counter, 0..31), one result bit per cycle:
- multiply: shift-add on operand magnitudes, 64-bit product
- divide/remainder: restoring division on operand magnitudes
- then enter FIX
REQ-006 FIX SHALL apply sign correction and result selection in one cycle, then enter DONE.
REQ-007 Latency SHALL be fixed: start sampled in cycle 0; busy=1 in cycles 1..33; done=1 and busy=0 in cycle 34 only.
REQ-008 Operand signedness SHALL be:
- signed×signed: MULH, DIV, REM
- signed×unsigned: MULHSU (in_1 signed)
- unsigned: MULHU, DIVU, REMU
- MUL: low word, identical for signed and unsigned
REQ-009 Result selection SHALL be:
- MUL: product[31:0]
- MULH, MULHSU, MULHU: product[63:32]
- DIV, DIVU: quotient
- REM, REMU: remainder, with the sign of the dividend
REQ-010 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder = in_1, for both signed and unsigned, with unchanged latency.
REQ-011 Signed overflow (in_1=0x80000000, in_2=0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0, with unchanged latency.
REQ-012 start SHALL be ignored while in CALC or FIX.
REQ-013 start asserted during the DONE cycle SHALL be accepted, giving back-to-back operations with no gap cycle.
REQ-014 kill=1 in any state SHALL move the FSM to IDLE at the next edge:
- no done pulse for the killed operation
- result keeps its previous value
- kill takes priority over start in the same cycle
REQ-015 done SHALL never be high in the same cycle as busy.
REQ-016 result SHALL change only on the edge leaving FIX.

Reset
REQ-017 reset=1 at a clock edge SHALL force IDLE, clear the counter and all internal registers, and drive busy=0, done=0, result=0x00000000.
REQ-018 reset SHALL take priority over kill and start.
REQ-019 Reset asserted mid-operation SHALL discard the operation with no done pulse.

Verification
REQ-020 Multiply cases:
- MUL, in_1=7, in_2=0xFFFFFFFD -> done in cycle 34, result=0xFFFFFFEB
- MULHU, 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE
- MULH, same operands -> result=0x00000000
REQ-021 Divide cases:
- DIV, in_1=0xFFFFFFF9 (-7), in_2=2 -> result=0xFFFFFFFD
- REM, same operands -> result=0xFFFFFFFF
- DIVU, same operands -> result=0x7FFFFFFC
REQ-022 Corner cases, each completing at cycle 34:
- DIV, in_1=5, in_2=0 -> result=0xFFFFFFFF
- REMU, in_1=5, in_2=0 -> result=5
- DIV, in_1=0x80000000, in_2=0xFFFFFFFF -> result=0x80000000
REQ-023 kill=1 in cycle 10 of a MUL -> IDLE in cycle 11, busy=0, no done pulse, result unchanged. A following start in IDLE is accepted normally.
REQ-024 reset=1 in cycle 20 of a DIV -> busy=0, done=0, result=0 from cycle 21. Also: start re-asserted during the DONE cycle -> second done exactly 34 cycles later. Also: start pulsed in cycle 5 while busy -> ignored.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative 32-cycle shift-add multiplier and restoring
// divider sharing one hi/lo register pair, with fixed 34-cycle start-to-done latency.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [5:0]  cnt_r;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] opd_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        neg_a_r;
  logic        neg_b_r;
  logic        div0_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] result_r;

  logic        accept_s;
  logic        sgn_a_s;
  logic        sgn_b_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] sum_s;
  logic [32:0] mul_hi_s;
  logic [32:0] shifted_s;
  logic [31:0] diff_s;
  logic        ge_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] fix_s;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  // Operand signedness decode and magnitude extraction at start time.
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (op)
      3'b001:  begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      3'b010:  begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
      3'b100:  begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      3'b110:  begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      default: begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
    endcase
    neg_a_s = sgn_a_s & in_1[31];
    neg_b_s = sgn_b_s & in_2[31];
    mag_a_s = cneg32(in_1, neg_a_s);
    mag_b_s = cneg32(in_2, neg_b_s);
  end

  // One iteration of shift-add (multiply) and restoring subtract (divide).
  always_comb begin
    sum_s     = {1'b0, hi_r} + {1'b0, opd_r};
    mul_hi_s  = lo_r[0] ? sum_s : {1'b0, hi_r};
    shifted_s = {hi_r, lo_r[31]};
    ge_s      = (shifted_s >= {1'b0, opd_r});
    diff_s    = shifted_s[31:0] - opd_r;
  end

  // Sign correction and result selection; divide-by-zero bypasses the datapath.
  always_comb begin
    prod_s = cneg64({hi_r, lo_r}, neg_a_r ^ neg_b_r);
    quo_s  = div0_r ? 32'hFFFF_FFFF : cneg32(lo_r, neg_a_r ^ neg_b_r);
    rem_s  = div0_r ? a_r : cneg32(hi_r, neg_a_r);
    case (op_r)
      3'b000:  fix_s = prod_s[31:0];
      3'b001:  fix_s = prod_s[63:32];
      3'b010:  fix_s = prod_s[63:32];
      3'b011:  fix_s = prod_s[63:32];
      3'b100:  fix_s = quo_s;
      3'b101:  fix_s = quo_s;
      3'b110:  fix_s = rem_s;
      3'b111:  fix_s = rem_s;
      default: fix_s = 32'd0;
    endcase
  end

  // Next-state logic; kill overrides everything except reset.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    if (kill) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = ST_CALC;
            accept_s    = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (cnt_r == 6'd31) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end
        ST_FIX:  state_nxt_s = ST_DONE;
        ST_DONE: begin
          if (start) begin
            state_nxt_s = ST_CALC;
            accept_s    = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 6'd0;
      op_r     <= 3'd0;
      a_r      <= 32'd0;
      opd_r    <= 32'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      div0_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CALC) || (state_nxt_s == ST_FIX);
      done_r  <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        op_r    <= op;
        a_r     <= in_1;
        neg_a_r <= neg_a_s;
        neg_b_r <= neg_b_s;
        div0_r  <= (in_2 == 32'd0);
        cnt_r   <= 6'd0;
        hi_r    <= 32'd0;
        // Multiply keeps the multiplier in lo and adds the multiplicand; divide
        // shifts the dividend out of lo and compares against the divisor.
        lo_r    <= op[2] ? mag_a_s : mag_b_s;
        opd_r   <= op[2] ? mag_b_s : mag_a_s;
      end else if ((state_r == ST_CALC) && !kill) begin
        cnt_r <= (cnt_r == 6'd31) ? 6'd0 : (cnt_r + 6'd1);
        if (op_r[2]) begin
          hi_r <= ge_s ? diff_s : shifted_s[31:0];
          lo_r <= {lo_r[30:0], ge_s};
        end else begin
          hi_r <= mul_hi_s[32:1];
          lo_r <= {mul_hi_s[0], lo_r[31:1]};
        end
      end
      if ((state_r == ST_FIX) && !kill) begin
        result_r <= fix_s;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, RV32M results, corner
// cases, kill, mid-operation reset, back-to-back and ignored start.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_assert;
  int          n_fail;
  logic [31:0] last_res;
  logic        seen;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .in_1   (in_1),
    .in_2   (in_2),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (cycle 0).
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int pulse_at);
    start = 1'b1;
    op    = o;
    in_1  = a;
    in_2  = b;
    @(posedge clk);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == pulse_at) begin
        start = 1'b1;
        op    = 3'b000;
        in_1  = 32'h0000_1234;
        in_2  = 32'h0000_0005;
      end
      check($sformatf("%s_busy_c%0d", tag, c), {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s_done_c34", tag), {30'd0, busy, done}, 32'd1);
    check($sformatf("%s_result", tag), result, exp);
    last_res = exp;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check($sformatf("%s_idle_flags", tag), {30'd0, busy, done}, 32'd0);
    check($sformatf("%s_idle_hold", tag), result, last_res);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    last_res = 32'd0;
    reset = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'd0;
    in_1  = 32'd0;
    in_2  = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_flags", {30'd0, busy, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;

    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    idle_check("mul");
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    idle_check("mulhu");
    do_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    idle_check("mulh");
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle_check("mulhsu");
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    idle_check("div");
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    idle_check("rem");
    do_op("divu_pulse", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 5);
    idle_check("divu_pulse");
    do_op("rem_negdiv", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
    idle_check("rem_negdiv");
    do_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    idle_check("div_by0");
    do_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
    idle_check("remu_by0");
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("b2b_mul", 3'b000, 32'd3, 32'd5, 32'd15, 0);
    idle_check("b2b_mul");

    start = 1'b1;
    kill  = 1'b1;
    op    = 3'b000;
    in_1  = 32'd2;
    in_2  = 32'd2;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    check("kill_over_start", {30'd0, busy, done}, 32'd0);

    start = 1'b1;
    op    = 3'b000;
    in_1  = 32'd9;
    in_2  = 32'd9;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_flags", {30'd0, busy, done}, 32'd0);
    check("kill_hold", result, last_res);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("kill_no_done", {31'd0, seen}, 32'd0);
    check("kill_hold_late", result, last_res);
    do_op("after_kill", 3'b000, 32'd9, 32'd9, 32'h0000_0051, 0);
    idle_check("after_kill");

    start = 1'b1;
    op    = 3'b100;
    in_1  = 32'd100;
    in_2  = 32'd7;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_res = 32'd0;
    check("midreset_flags", {30'd0, busy, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midreset_no_done", {31'd0, seen}, 32'd0);
    do_op("after_reset", 3'b101, 32'd100, 32'd7, 32'd14, 0);
    idle_check("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
